// File: rtl/simplex_rx_if.sv
// Decoded RX block stream from the lane block-sync/decoder into the lane monitor.
interface simplex_rx_if;
  logic rx_block_lock;
  logic rx_block_valid;
  logic rx_header_err;
  logic rx_is_sp;
  logic rx_is_idle;
  logic rx_is_ver;
  logic rx_lanes_deskewed;

  modport master (
    output rx_block_lock, rx_block_valid, rx_header_err,
           rx_is_sp, rx_is_idle, rx_is_ver, rx_lanes_deskewed
  );

  modport slave (
    input  rx_block_lock, rx_block_valid, rx_header_err,
           rx_is_sp, rx_is_idle, rx_is_ver, rx_lanes_deskewed
  );
endinterface

// File: rtl/simplex_rx_monitor.sv
// Simplex Aurora RX lane monitor: qualifies alignment, bonding and verification,
// with per-phase watchdog and a fixed-length reset pulse on any fault.
module simplex_rx_monitor #(
  parameter int ALIGN_CNT   = 64,
  parameter int BOND_CNT    = 16,
  parameter int VER_CNT     = 64,
  parameter int VER_ERR_MAX = 4,
  parameter int TIMEOUT     = 65536,
  parameter int RESET_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        single_lane,
  simplex_rx_if.slave lane,
  output logic        simplex_aligned,
  output logic        simplex_bonded,
  output logic        simplex_verified,
  output logic        simplex_reset,
  output logic [7:0]  fault_count
);

  localparam int RUN_MAX = (ALIGN_CNT > BOND_CNT) ? ALIGN_CNT : BOND_CNT;
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int VW = $clog2(VER_CNT + 1);
  localparam int EW = $clog2(VER_ERR_MAX + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [2:0] {
    S_ALIGN, S_BOND, S_VERIFY, S_DONE, S_FAULT
  } state_t;

  state_t        state;
  logic [RW-1:0] run_cnt;
  logic [VW-1:0] ver_cnt;
  logic [EW-1:0] err_cnt;
  logic [WW-1:0] wd_cnt;
  logic [HW-1:0] hold_cnt;

  logic one_type, good, bad, ver_good, bond_good;
  logic timed, wd_exp, lock_lost, err_hit, fault_hit;

  assign one_type  = (lane.rx_is_sp ^ lane.rx_is_idle ^ lane.rx_is_ver) &
                     ~(lane.rx_is_sp & lane.rx_is_idle) &
                     ~(lane.rx_is_sp & lane.rx_is_ver) &
                     ~(lane.rx_is_idle & lane.rx_is_ver);
  assign good      = lane.rx_block_valid & ~lane.rx_header_err & lane.rx_block_lock & one_type;
  assign bad       = lane.rx_block_valid & ~good;
  assign ver_good  = good & lane.rx_is_ver;
  assign bond_good = good & lane.rx_is_idle & lane.rx_lanes_deskewed;

  // Fault sources are resolved ahead of any completion in the same cycle.
  assign timed     = (state == S_ALIGN) || (state == S_BOND) || (state == S_VERIFY);
  assign wd_exp    = timed && (wd_cnt == WW'(TIMEOUT - 1));
  assign lock_lost = !lane.rx_block_lock &&
                     ((state == S_BOND) || (state == S_VERIFY) || (state == S_DONE));
  assign err_hit   = (state == S_VERIFY) && lane.rx_block_valid && !ver_good &&
                     (err_cnt == EW'(VER_ERR_MAX));
  assign fault_hit = wd_exp || lock_lost || err_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_ALIGN;
      run_cnt          <= '0;
      ver_cnt          <= '0;
      err_cnt          <= '0;
      wd_cnt           <= '0;
      hold_cnt         <= '0;
      simplex_aligned  <= 1'b0;
      simplex_bonded   <= 1'b0;
      simplex_verified <= 1'b0;
      simplex_reset    <= 1'b0;
      fault_count      <= '0;
    end else if (fault_hit) begin
      state            <= S_FAULT;
      run_cnt          <= '0;
      ver_cnt          <= '0;
      err_cnt          <= '0;
      wd_cnt           <= '0;
      hold_cnt         <= '0;
      simplex_aligned  <= 1'b0;
      simplex_bonded   <= 1'b0;
      simplex_verified <= 1'b0;
      simplex_reset    <= 1'b1;
      if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
    end else begin
      case (state)
        S_ALIGN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (!lane.rx_block_lock || bad) begin
            run_cnt <= '0;
          end else if (good) begin
            if (run_cnt == RW'(ALIGN_CNT - 1)) begin
              run_cnt         <= '0;
              wd_cnt          <= '0;
              simplex_aligned <= 1'b1;
              if (single_lane) begin
                simplex_bonded <= 1'b1;
                state          <= S_VERIFY;
              end else begin
                state <= S_BOND;
              end
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
        end
        S_BOND: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (bond_good) begin
            if (run_cnt == RW'(BOND_CNT - 1)) begin
              run_cnt        <= '0;
              wd_cnt         <= '0;
              simplex_bonded <= 1'b1;
              state          <= S_VERIFY;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else if (lane.rx_block_valid) begin
            run_cnt <= '0;
          end
        end
        S_VERIFY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (ver_good) begin
            if (ver_cnt == VW'(VER_CNT - 1)) begin
              ver_cnt          <= '0;
              err_cnt          <= '0;
              wd_cnt           <= '0;
              simplex_verified <= 1'b1;
              state            <= S_DONE;
            end else begin
              ver_cnt <= ver_cnt + 1'b1;
            end
          end else if (lane.rx_block_valid) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
        S_DONE: ;
        S_FAULT: begin
          if (hold_cnt == HW'(RESET_HOLD - 1)) begin
            hold_cnt      <= '0;
            simplex_reset <= 1'b0;
            state         <= S_ALIGN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_simplex_rx_monitor.sv
// Directed bench for simplex_rx_monitor: behavioural phase model checked every cycle,
// plus literal expectations at the points the scenarios call out.
module tb_simplex_rx_monitor;
  localparam int ALIGN_CNT   = 4;
  localparam int BOND_CNT    = 2;
  localparam int VER_CNT     = 4;
  localparam int VER_ERR_MAX = 1;
  localparam int TIMEOUT     = 32;
  localparam int RESET_HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       single_lane = 1'b0;
  logic       simplex_aligned, simplex_bonded, simplex_verified, simplex_reset;
  logic [7:0] fault_count;

  simplex_rx_if lane_if();

  simplex_rx_monitor #(
    .ALIGN_CNT(ALIGN_CNT), .BOND_CNT(BOND_CNT), .VER_CNT(VER_CNT),
    .VER_ERR_MAX(VER_ERR_MAX), .TIMEOUT(TIMEOUT), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .single_lane(single_lane), .lane(lane_if.slave),
    .simplex_aligned(simplex_aligned), .simplex_bonded(simplex_bonded),
    .simplex_verified(simplex_verified), .simplex_reset(simplex_reset),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t dut=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model: phase 0..3 = align/bond/verify/done; faulted while rs_left > 0.
  int m_phase, m_progress, m_errs, m_age, m_rs_left, m_faults;
  bit m_al, m_bo, m_ve;
  bit m_good, m_fault;
  int m_kinds;

  task automatic model_clear();
    m_phase = 0; m_progress = 0; m_errs = 0; m_age = 0;
    m_al = 0; m_bo = 0; m_ve = 0;
  endtask

  initial begin
    model_clear();
    m_rs_left = 0;
    m_faults  = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
      m_rs_left = 0;
      m_faults  = 0;
    end else if (m_rs_left > 0) begin
      m_rs_left--;
      if (m_rs_left == 0) model_clear();
    end else begin
      m_kinds = int'(lane_if.rx_is_sp) + int'(lane_if.rx_is_idle) + int'(lane_if.rx_is_ver);
      m_good  = lane_if.rx_block_valid && !lane_if.rx_header_err &&
                lane_if.rx_block_lock && (m_kinds == 1);
      m_fault = 0;
      if (m_phase <= 2 && m_age == TIMEOUT - 1) m_fault = 1;
      if (m_phase >= 1 && !lane_if.rx_block_lock) m_fault = 1;
      if (m_phase == 2 && lane_if.rx_block_valid && !(m_good && lane_if.rx_is_ver) &&
          m_errs + 1 > VER_ERR_MAX) m_fault = 1;
      if (m_fault) begin
        model_clear();
        m_rs_left = RESET_HOLD;
        if (m_faults < 255) m_faults++;
      end else begin
        m_age++;
        if (m_phase == 0) begin
          if (!lane_if.rx_block_lock || (lane_if.rx_block_valid && !m_good)) m_progress = 0;
          else if (m_good) m_progress++;
          if (m_progress == ALIGN_CNT) begin
            m_al = 1; m_progress = 0; m_age = 0;
            if (single_lane) begin m_bo = 1; m_phase = 2; end
            else m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (m_good && lane_if.rx_is_idle && lane_if.rx_lanes_deskewed) m_progress++;
          else if (lane_if.rx_block_valid) m_progress = 0;
          if (m_progress == BOND_CNT) begin
            m_bo = 1; m_progress = 0; m_age = 0; m_phase = 2;
          end
        end else if (m_phase == 2) begin
          if (m_good && lane_if.rx_is_ver) m_progress++;
          else if (lane_if.rx_block_valid) m_errs++;
          if (m_progress == VER_CNT) begin
            m_ve = 1; m_progress = 0; m_errs = 0; m_age = 0; m_phase = 3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("aligned",  int'(simplex_aligned),  int'(m_al));
      chk("bonded",   int'(simplex_bonded),   int'(m_bo));
      chk("verified", int'(simplex_verified), int'(m_ve));
      chk("reset",    int'(simplex_reset),    int'(m_rs_left > 0));
      chk("faults",   int'(fault_count),      m_faults);
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that sampled it.
  task automatic cyc(input bit v, input bit sp, input bit idle, input bit ver,
                     input bit herr, input bit lock, input bit desk);
    lane_if.rx_block_valid    = v;
    lane_if.rx_is_sp          = sp;
    lane_if.rx_is_idle        = idle;
    lane_if.rx_is_ver         = ver;
    lane_if.rx_header_err     = herr;
    lane_if.rx_block_lock     = lock;
    lane_if.rx_lanes_deskewed = desk;
    @(posedge clk);
    #1;
  endtask

  task automatic sp_n(input int n);   repeat (n) cyc(1, 1, 0, 0, 0, 1, 1); endtask
  task automatic idle_n(input int n); repeat (n) cyc(1, 0, 1, 0, 0, 1, 1); endtask
  task automatic ver_n(input int n);  repeat (n) cyc(1, 0, 0, 1, 0, 1, 1); endtask
  task automatic gap_n(input int n);  repeat (n) cyc(0, 0, 0, 0, 0, 1, 1); endtask
  task automatic herr_blk();          cyc(1, 1, 0, 0, 1, 1, 1); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gap_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1, 1);
    do_reset();
    chk_en = 1'b1;
    chk("rst_aligned", int'(simplex_aligned), 0);
    chk("rst_reset",   int'(simplex_reset),   0);
    chk("rst_faults",  int'(fault_count),     0);

    // Multi-lane happy path
    single_lane = 1'b0;
    sp_n(3);
    chk("ml_al_early", int'(simplex_aligned), 0);
    sp_n(1);
    chk("ml_al", int'(simplex_aligned), 1);
    chk("ml_bo_early", int'(simplex_bonded), 0);
    idle_n(1);
    chk("ml_bo_mid", int'(simplex_bonded), 0);
    idle_n(1);
    chk("ml_bo", int'(simplex_bonded), 1);
    ver_n(3);
    chk("ml_ve_early", int'(simplex_verified), 0);
    ver_n(1);
    chk("ml_ve", int'(simplex_verified), 1);
    gap_n(3);
    chk("ml_hold", int'(simplex_verified), 1);

    // Single-lane path: bonding skipped
    do_reset();
    single_lane = 1'b1;
    sp_n(4);
    chk("sl_al", int'(simplex_aligned), 1);
    chk("sl_bo", int'(simplex_bonded), 1);
    single_lane = 1'b0;
    ver_n(4);
    chk("sl_ve", int'(simplex_verified), 1);

    // Alignment disturbance, then VERIFY error limit
    do_reset();
    sp_n(3);
    herr_blk();
    sp_n(3);
    chk("dist_al_early", int'(simplex_aligned), 0);
    sp_n(1);
    chk("dist_al", int'(simplex_aligned), 1);
    idle_n(2);
    chk("err_bo", int'(simplex_bonded), 1);
    herr_blk();
    chk("err_first", int'(simplex_reset), 0);
    herr_blk();
    chk("err_rs1", int'(simplex_reset), 1);
    chk("err_al0", int'(simplex_aligned), 0);
    chk("err_bo0", int'(simplex_bonded), 0);
    chk("err_fc", int'(fault_count), 1);
    gap_n(2);
    chk("err_rs3", int'(simplex_reset), 1);
    gap_n(1);
    chk("err_rs_end", int'(simplex_reset), 0);

    // Re-qualify, then lock loss in DONE
    sp_n(4);
    idle_n(2);
    ver_n(4);
    chk("ll_ve", int'(simplex_verified), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ll_rs", int'(simplex_reset), 1);
    chk("ll_ve0", int'(simplex_verified), 0);
    chk("ll_fc", int'(fault_count), 2);
    gap_n(3);
    chk("ll_rs_end", int'(simplex_reset), 0);
    sp_n(4);
    idle_n(2);
    ver_n(4);
    chk("ll_req_ve", int'(simplex_verified), 1);
    chk("ll_req_fc", int'(fault_count), 2);

    // BOND watchdog, then rst_n during the fault pulse
    do_reset();
    sp_n(4);
    gap_n(31);
    chk("wd_pre", int'(simplex_reset), 0);
    gap_n(1);
    chk("wd_rs", int'(simplex_reset), 1);
    chk("wd_fc", int'(fault_count), 1);
    gap_n(1);
    chk("wd_rs2", int'(simplex_reset), 1);
    rst_n = 1'b0;
    gap_n(1);
    chk("rp_rs", int'(simplex_reset), 0);
    chk("rp_fc", int'(fault_count), 0);
    rst_n = 1'b1;
    gap_n(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
